// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback/reservation/scoreboard bus for regfile_wb_arbiter
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NREG = 1 << ADDR_W;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              rsv_valid;
    logic              rsv_ready;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              hazard;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   busy;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  m_valid, m_addr, m_data,
        input  rsv_valid, rsv_addr, rs_addr, rt_addr,
        output a_ready, m_ready, rsv_ready, hazard,
        output wr_en, wr_addr, wr_data, busy
    );

    modport master (
        output a_valid, a_addr, a_data,
        output m_valid, m_addr, m_data,
        output rsv_valid, rsv_addr, rs_addr, rt_addr,
        input  a_ready, m_ready, rsv_ready, hazard,
        input  wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file write arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int ZERO_PROTECT = 1,
    parameter int ARB_MODE     = 0
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {GRANT_A = 1'b0, GRANT_M = 1'b1} grant_t;

    grant_t            last_grant;
    logic              grant_a;
    logic              grant_m;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_zero;
    logic              rsv_zero;
    logic              rsv_ready_c;
    logic              rsv_set;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_next;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (!rst) begin
            if (bus.a_valid && bus.m_valid) begin
                // Round-robin hands the tie to whoever did not win last time.
                if (ARB_MODE != 0 || last_grant == GRANT_A) grant_m = 1'b1;
                else                                        grant_a = 1'b1;
            end else begin
                grant_a = bus.a_valid;
                grant_m = bus.m_valid;
            end
        end
    end

    assign xfer     = grant_a | grant_m;
    assign sel_addr = grant_m ? bus.m_addr : bus.a_addr;
    assign sel_data = grant_m ? bus.m_data : bus.a_data;
    assign sel_zero = (ZERO_PROTECT != 0) && (sel_addr == '0);
    assign rsv_zero = (ZERO_PROTECT != 0) && (bus.rsv_addr == '0);

    always_comb begin
        rsv_ready_c = 1'b0;
        if (!rst) rsv_ready_c = rsv_zero | ~busy_q[bus.rsv_addr];
    end

    assign rsv_set = bus.rsv_valid & rsv_ready_c & ~rsv_zero;

    // Clear first, then set, so a same-edge set keeps the register reserved.
    always_comb begin
        busy_next = busy_q;
        if (wr_en_q) busy_next[wr_addr_q] = 1'b0;
        if (rsv_set) busy_next[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= '0;
            last_grant <= GRANT_A;
        end else begin
            wr_en_q <= xfer & ~sel_zero;
            busy_q  <= busy_next;
            if (xfer) begin
                wr_addr_q  <= sel_addr;
                wr_data_q  <= sel_data;
                last_grant <= grant_m ? GRANT_M : GRANT_A;
            end
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.m_ready   = grant_m;
    assign bus.rsv_ready = rsv_ready_c;
    assign bus.hazard    = busy_q[bus.rs_addr] | busy_q[bus.rt_addr];
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench driving round-robin and fixed-priority instances in lockstep
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, m_valid, rsv_valid;
    logic [4:0]  a_addr, m_addr, rsv_addr, rs_addr, rt_addr;
    logic [31:0] a_data, m_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [36:0] q0[$];
    logic [36:0] q1[$];
    logic        lg[2];
    logic [31:0] eb[2];

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_PROTECT(1), .ARB_MODE(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_PROTECT(1), .ARB_MODE(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    assign if0.a_valid = a_valid;     assign if1.a_valid = a_valid;
    assign if0.a_addr = a_addr;       assign if1.a_addr = a_addr;
    assign if0.a_data = a_data;       assign if1.a_data = a_data;
    assign if0.m_valid = m_valid;     assign if1.m_valid = m_valid;
    assign if0.m_addr = m_addr;       assign if1.m_addr = m_addr;
    assign if0.m_data = m_data;       assign if1.m_data = m_data;
    assign if0.rsv_valid = rsv_valid; assign if1.rsv_valid = rsv_valid;
    assign if0.rsv_addr = rsv_addr;   assign if1.rsv_addr = rsv_addr;
    assign if0.rs_addr = rs_addr;     assign if1.rs_addr = rs_addr;
    assign if0.rt_addr = rt_addr;     assign if1.rt_addr = rt_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic eval_dut(input int d, input logic ar, input logic mr, input logic rr,
                            input logic hz, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [31:0] bz);
        logic [36:0] e;
        logic        have, commit, er, ega, egm;
        logic [4:0]  caddr, taddr;
        logic [31:0] nb;
        string       p;
        p      = (d == 0) ? "rr_" : "fp_";
        have   = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        commit = 1'b0;
        caddr  = 5'd0;
        if (have) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check({p, "wr_en"}, 64'(we), 64'd1);
            check({p, "wr_addr"}, 64'(wa), 64'(e[36:32]));
            check({p, "wr_data"}, 64'(wd), 64'(e[31:0]));
            commit = 1'b1;
            caddr  = e[36:32];
        end else begin
            check({p, "wr_en_idle"}, 64'(we), 64'd0);
        end
        check({p, "busy"}, 64'(bz), 64'(eb[d]));
        check({p, "hazard"}, 64'(hz), 64'(eb[d][rs_addr] | eb[d][rt_addr]));
        if (rst) begin
            check({p, "rst_ready"}, 64'({ar, mr, rr}), 64'd0);
            lg[d] = 1'b0;
            eb[d] = 32'd0;
            if (d == 0) q0.delete(); else q1.delete();
            return;
        end
        er = (rsv_addr == 5'd0) ? 1'b1 : ~eb[d][rsv_addr];
        check({p, "rsv_ready"}, 64'(rr), 64'(er));
        ega = 1'b0;
        egm = 1'b0;
        if (a_valid && m_valid) begin
            if (d == 1 || !lg[d]) egm = 1'b1; else ega = 1'b1;
        end else begin
            ega = a_valid;
            egm = m_valid;
        end
        check({p, "a_ready"}, 64'(ar), 64'(ega));
        check({p, "m_ready"}, 64'(mr), 64'(egm));
        if (ega || egm) begin
            lg[d] = egm;
            taddr = egm ? m_addr : a_addr;
            if (taddr != 5'd0) begin
                if (d == 0) q0.push_back({taddr, egm ? m_data : a_data});
                else        q1.push_back({taddr, egm ? m_data : a_data});
            end
        end
        nb = eb[d];
        if (commit) nb[caddr] = 1'b0;
        if (rsv_valid && er && rsv_addr != 5'd0) nb[rsv_addr] = 1'b1;
        eb[d] = nb;
    endtask

    task automatic tick();
        @(negedge clk);
        eval_dut(0, if0.a_ready, if0.m_ready, if0.rsv_ready, if0.hazard,
                 if0.wr_en, if0.wr_addr, if0.wr_data, if0.busy);
        eval_dut(1, if1.a_ready, if1.m_ready, if1.rsv_ready, if1.hazard,
                 if1.wr_en, if1.wr_addr, if1.wr_data, if1.busy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; m_valid = 0; rsv_valid = 0;
    endtask

    initial begin
        rst = 1; idle();
        a_addr = 0; m_addr = 0; rsv_addr = 0; rs_addr = 0; rt_addr = 0;
        a_data = 0; m_data = 0;
        lg[0] = 0; lg[1] = 0; eb[0] = 0; eb[1] = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        tick();

        // reserve 7, write it back from A, hazard clears after the commit edge
        rs_addr = 7; rt_addr = 3;
        rsv_valid = 1; rsv_addr = 7; tick(); rsv_valid = 0;
        a_valid = 1; a_addr = 7; a_data = 32'h1234; tick(); a_valid = 0;
        tick(); tick();

        // both requesters held for 4 cycles, then M drops
        a_valid = 1; a_addr = 3; a_data = 32'haaaa_0003;
        m_valid = 1; m_addr = 4; m_data = 32'h5555_0004;
        for (int i = 0; i < 4; i++) tick();
        m_valid = 0; tick();
        idle(); tick(); tick();

        // double reservation of 5 waits for writeback commit
        rs_addr = 5; rt_addr = 5;
        rsv_valid = 1; rsv_addr = 5; tick();
        tick(); tick();
        m_valid = 1; m_addr = 5; m_data = 32'hdead_0005; tick(); m_valid = 0;
        tick(); tick(); rsv_valid = 0;
        a_valid = 1; a_addr = 5; a_data = 32'h0000_0505; tick(); a_valid = 0;
        tick(); tick();

        // register 0 is write- and reservation-protected
        a_valid = 1; a_addr = 0; a_data = 32'h0000_ffff; tick(); a_valid = 0;
        rsv_valid = 1; rsv_addr = 0; rs_addr = 0; tick(); rsv_valid = 0;
        tick();

        // randomised traffic
        for (int i = 0; i < 60; i++) begin
            a_valid = 1'($urandom_range(0, 1)); a_addr = 5'($urandom_range(0, 31));
            a_data = $urandom;
            m_valid = 1'($urandom_range(0, 1)); m_addr = 5'($urandom_range(0, 31));
            m_data = $urandom;
            rsv_valid = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 31));
            rs_addr = 5'($urandom_range(0, 31)); rt_addr = 5'($urandom_range(0, 31));
            tick();
        end
        idle(); tick(); tick();

        // reset right after an A transfer; tie afterwards goes to M
        rsv_valid = 1; rsv_addr = 12; tick(); rsv_valid = 0;
        a_valid = 1; a_addr = 9; a_data = 32'h9999; tick(); a_valid = 0;
        rst = 1; tick(); rst = 0;
        tick();
        a_valid = 1; a_addr = 10; a_data = 32'h1010;
        m_valid = 1; m_addr = 11; m_data = 32'h1111;
        tick(); idle(); tick(); tick();

        check("rr_queue_drained", 64'(q0.size()), 64'd0);
        check("fp_queue_drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU results (port A) and load results (port M).
- Also keeps a per-register pending-write scoreboard, so decode can stall on a read-after-write hazard.
- Sits between execute/memory stages and the register file; its wr_* outputs drive the register file's write address, data and enable pins directly.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, width of register address; NREG = 2**ADDR_W registers.
- ZERO_PROTECT, 1, when 1, writes and reservations to register 0 are discarded (handshake still completes).
- ARB_MODE, 0, 0 = round-robin between A and M; 1 = fixed priority, M over A.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  ALU writeback request.
- a_ready  out  1  ALU request granted this cycle.
- a_addr  in  ADDR_W  ALU destination register.
- a_data  in  DATA_W  ALU result.
- m_valid  in  1  load writeback request.
- m_ready  out  1  load request granted this cycle.
- m_addr  in  ADDR_W  load destination register.
- m_data  in  DATA_W  load data.
- rsv_valid  in  1  decode reserves a destination register at issue.
- rsv_ready  out  1  reservation accepted.
- rsv_addr  in  ADDR_W  register to reserve.
- rs_addr  in  ADDR_W  decode source register 1.
- rt_addr  in  ADDR_W  decode source register 2.
- hazard  out  1  busy[rs_addr] | busy[rt_addr].
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_W  register-file write address.
- wr_data  out  DATA_W  register-file write data.
- busy  out  NREG  scoreboard vector.

Behaviour:
- Reset: single clock, synchronous, active-high reset. On rst high at a rising edge:
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - busy = 0.
  - last_grant = A, so M wins the first tie in round-robin mode.
- a_ready, m_ready, rsv_ready and hazard are combinational. While rst is high, all three readies are held at 0.
- Arbitration, combinational, every cycle:
  - Only one valid: that requester gets ready = 1.
  - Both valid, ARB_MODE = 0: grant the requester not in last_grant.
  - Both valid, ARB_MODE = 1: grant M.
  - Neither valid: both readies = 0.
  - At most one ready is high per cycle.
- Transfer occurs on valid & ready at a rising edge.
  - Requesters must hold addr/data stable while valid is high and ready is low.
  - last_grant updates only on a transfer.
- Write latency is 1 cycle.
  - The cycle after a transfer: wr_en = 1, and wr_addr/wr_data hold the transferred values.
  - With no transfer: wr_en = 0, and wr_addr/wr_data hold their previous values.
  - If ZERO_PROTECT = 1 and the transferred addr = 0: wr_en stays 0.
  - Sustained throughput is one write per cycle.
- Scoreboard:
  - rsv_ready = ~busy[rsv_addr], or 1 when ZERO_PROTECT = 1 and rsv_addr = 0.
  - Set: at the edge where rsv_valid & rsv_ready, busy[rsv_addr] goes to 1 (never for register 0 when ZERO_PROTECT = 1).
  - Clear: at the edge where wr_en = 1, busy[wr_addr] goes to 0. This is the same edge the register file commits the write, so hazard never drops before the data is readable.
  - Set and clear of the same register at the same edge: set wins, busy stays 1.
  - Writeback to a non-busy register is legal; busy is unchanged.
- Reset mid-operation: any transfer in flight is dropped. wr_en is 0 the cycle after reset and all busy bits clear; requesters must re-present after reset.

Test Plan:
- Reset, then rsv 7, then a_valid addr 7 data 0x1234 for one cycle → a_ready = 1. Next cycle: wr_en = 1, wr_addr = 7, wr_data = 0x1234. Cycle after: busy[7] = 0, hazard (rs = 7) = 0.
- ARB_MODE 0, a_valid and m_valid held high for 4 cycles → grants M, A, M, A. wr_en = 1 on 4 consecutive cycles. Each requester sees ready exactly twice.
- ARB_MODE 1, both valid 3 cycles → m_ready = 1 every cycle, a_ready = 0. a_ready = 1 on the first cycle m_valid drops.
- rsv 5 accepted; second rsv 5 → rsv_ready = 0 until the writeback to 5 commits. Then rsv_ready = 1, and a new rsv at the clearing edge leaves busy[5] = 1.
- ZERO_PROTECT 1: a_valid addr 0 data 0xFFFF → a_ready = 1, wr_en stays 0. rsv 0 → rsv_ready = 1, busy[0] stays 0.
- rst asserted the cycle after an A transfer → wr_en = 0 next cycle, busy = 0, last_grant = A.
